ddr_clk_synth: RTL and testbench



---
 rtl/ddr_clk_pkg.sv | 13 +
 rtl/ddr_lock_counter.sv | 36 +++
 rtl/ddr_clk_synth.sv | 100 ++++++++++
 tb/tb_ddr_clk_synth.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ddr_clk_pkg.sv
// Shared constants and helpers for the DDR clock synthesis block.
package ddr_clk_pkg;

   localparam int LOCK1_CYCLES_DEF = 16;
   localparam int LOCK2_CYCLES_DEF = 8;
   localparam int FB_TIMEOUT_DEF   = 8;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ddr_lock_counter.sv
// Saturating lock counter: clear wins, counts while enabled, stops at MAX.
// done is registered and goes high on the same edge the count reaches MAX.
module ddr_lock_counter
   import ddr_clk_pkg::*;
#(
   parameter int MAX = 16,
   parameter int W   = cnt_w(MAX)
) (
   input  logic sim_2x_clk,
   input  logic clear,
   input  logic en,
   output logic done
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   // Next count: clear, increment while enabled, hold once saturated.
   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (en && (cnt != MAX_V))
         cnt_nxt = cnt + 1'b1;
   end

   // Count register plus done flag looked up from the next value so that
   // done rises on the edge the count lands on MAX, not one edge later.
   always_ff @(posedge sim_2x_clk) begin
      cnt  <= cnt_nxt;
      done <= (cnt_nxt == MAX_V);
   end

endmodule

// File: rtl/ddr_clk_synth.sv
// Behavioural DDR clock front end: divides the 2x reference to the DDR
// clock pair and sequences two lock indications.
// Optional feedback supervision is compiled in with DDR_CLK_FB_CHECK_EN.
module ddr_clk_synth
   import ddr_clk_pkg::*;
#(
   parameter int LOCK1_CYCLES = LOCK1_CYCLES_DEF,
   parameter int LOCK2_CYCLES = LOCK2_CYCLES_DEF,
   parameter int FB_TIMEOUT   = FB_TIMEOUT_DEF
) (
   input  logic sim_2x_clk,
   input  logic rst,
   input  logic ddr_fb_clk_in,
   output logic ddr_clk,
   output logic ddr_clk_n,
   output logic ddr_2x_clk,
   output logic ddr_fb_clk_out,
   output logic dcm1_lock,
   output logic dcm2_lock
);

   logic ddr_clk_q;
   logic fb_ok;     // stage 1 may count
   logic fb_lost;   // feedback watchdog expired

   // Divide-by-2: toggles every reference edge, parked low in reset.
   always_ff @(posedge sim_2x_clk) begin
      if (rst)
         ddr_clk_q <= 1'b0;
      else
         ddr_clk_q <= ~ddr_clk_q;
   end

   assign ddr_2x_clk     = sim_2x_clk;
   assign ddr_clk        = ddr_clk_q;
   assign ddr_clk_n      = ~ddr_clk_q;
   assign ddr_fb_clk_out = ddr_clk_q;

`ifdef DDR_CLK_FB_CHECK_EN
   localparam int WD_W = cnt_w(FB_TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(FB_TIMEOUT);

   logic fb_s1, fb_s2, fb_s3;
   logic fb_edge;
   logic fb_seen;
   logic [WD_W-1:0] wd;

   assign fb_edge = fb_s2 & ~fb_s3;

   // Two-flop synchronizer, a third flop for edge detect, and a sticky
   // flag recording that the loop has produced at least one edge.
   always_ff @(posedge sim_2x_clk) begin
      if (rst) begin
         fb_s1   <= 1'b0;
         fb_s2   <= 1'b0;
         fb_s3   <= 1'b0;
         fb_seen <= 1'b0;
      end else begin
         fb_s1 <= ddr_fb_clk_in;
         fb_s2 <= fb_s1;
         fb_s3 <= fb_s2;
         if (fb_edge)
            fb_seen <= 1'b1;
      end
   end

   // Watchdog: cycles since the last feedback edge, saturating at the limit
   // so a dead loop keeps the locks held down until edges return.
   always_ff @(posedge sim_2x_clk) begin
      if (rst || fb_edge)
         wd <= '0;
      else if (fb_seen && (wd != WD_MAX))
         wd <= wd + 1'b1;
   end

   assign fb_ok   = fb_seen;
   assign fb_lost = fb_seen && (wd == WD_MAX) && !fb_edge;
`else
   logic fb_unused;
   assign fb_unused = ddr_fb_clk_in;
   assign fb_ok     = 1'b1;
   assign fb_lost   = 1'b0;
`endif

   ddr_lock_counter #(.MAX(LOCK1_CYCLES)) u_lock1 (
      .sim_2x_clk (sim_2x_clk),
      .clear      (rst | fb_lost),
      .en         (fb_ok),
      .done       (dcm1_lock)
   );

   // Stage 2 clears on any event that drops stage 1 so both fall together.
   ddr_lock_counter #(.MAX(LOCK2_CYCLES)) u_lock2 (
      .sim_2x_clk (sim_2x_clk),
      .clear      (rst | fb_lost | ~dcm1_lock),
      .en         (dcm1_lock),
      .done       (dcm2_lock)
   );

endmodule

// File: tb/tb_ddr_clk_synth.sv
// Bench for ddr_clk_synth: two instances (default and 1/1 lock lengths)
// checked every cycle against an edges-since-release model.
module tb_ddr_clk_synth;

   localparam int A_L1 = 16, A_L2 = 8;
   localparam int B_L1 = 1,  B_L2 = 1;
   localparam int FB_T = 8;
`ifdef DDR_CLK_FB_CHECK_EN
   localparam int LAT = 4;   // feedback sync + edge detect + seen flag
`else
   localparam int LAT = 0;
`endif

   localparam int M_EXACT = 0;  // locks follow edge count
   localparam int M_ZERO  = 1;  // locks must be low
   localparam int M_FREE  = 2;  // locks in transition, not compared

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fb_force = 1'b0;

   logic a_clk, a_clk_n, a_2x, a_fbo, a_l1, a_l2, a_fbi;
   logic b_clk, b_clk_n, b_2x, b_fbo, b_l1, b_l2, b_fbi;

   assign a_fbi = fb_force ? 1'b0 : a_fbo;
   assign b_fbi = fb_force ? 1'b0 : b_fbo;

   int n = 0;          // rising edges since rst last sampled high
   int mode = M_EXACT;
   bit cmp_on = 1'b0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ddr_clk_synth #(.LOCK1_CYCLES(A_L1), .LOCK2_CYCLES(A_L2), .FB_TIMEOUT(FB_T)) dut_a (
      .sim_2x_clk(clk), .rst(rst), .ddr_fb_clk_in(a_fbi),
      .ddr_clk(a_clk), .ddr_clk_n(a_clk_n), .ddr_2x_clk(a_2x),
      .ddr_fb_clk_out(a_fbo), .dcm1_lock(a_l1), .dcm2_lock(a_l2));

   ddr_clk_synth #(.LOCK1_CYCLES(B_L1), .LOCK2_CYCLES(B_L2), .FB_TIMEOUT(FB_T)) dut_b (
      .sim_2x_clk(clk), .rst(rst), .ddr_fb_clk_in(b_fbi),
      .ddr_clk(b_clk), .ddr_clk_n(b_clk_n), .ddr_2x_clk(b_2x),
      .ddr_fb_clk_out(b_fbo), .dcm1_lock(b_l1), .dcm2_lock(b_l2));

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (n=%0d)", nm, act, exp, n);
      end
   endtask

   // Model state: edges since release.
   always @(posedge clk) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("a_clk", a_clk, n % 2);
         check("b_clk", b_clk, n % 2);
         check("a_clk_n", a_clk_n, 1 - (n % 2));
         check("b_clk_n", b_clk_n, 1 - (n % 2));
         check("a_fbo", a_fbo, n % 2);
         check("b_fbo", b_fbo, n % 2);
         check("a_2x", a_2x, 0);
         check("b_2x", b_2x, 0);
         if (mode == M_EXACT) begin
            check("a_l1", a_l1, int'(n >= A_L1 + LAT));
            check("a_l2", a_l2, int'(n >= A_L1 + A_L2 + LAT));
            check("b_l1", b_l1, int'(n >= B_L1 + LAT));
            check("b_l2", b_l2, int'(n >= B_L1 + B_L2 + LAT));
         end else if (mode == M_ZERO) begin
            check("a_l1_zero", a_l1, 0);
            check("a_l2_zero", a_l2, 0);
            check("b_l1_zero", b_l1, 0);
            check("b_l2_zero", b_l2, 0);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      check("rst_ddr_clk", a_clk, 0);
      check("rst_ddr_clk_n", a_clk_n, 1);
      check("rst_l1", a_l1, 0);
      rst = 1'b0;

      // First edge raises ddr_clk; reset pulse landing on edge 30
      @(negedge clk);
      check("edge1_clk", a_clk, 1);
      repeat (28) @(negedge clk);
      check("edge29_n", n, 29);
      rst = 1'b1;
      @(negedge clk);
      check("pulse_clk", a_clk, 0);
      check("pulse_l1", a_l1, 0);
      check("pulse_l2", a_l2, 0);
      rst = 1'b0;

      // Pin lock edges with hand-derived values
      repeat (B_L1 + LAT) @(negedge clk);
      check("b_l1_edge", b_l1, 1);
      check("b_l2_before", b_l2, 0);
      @(negedge clk);
      check("b_l2_edge", b_l2, 1);
      repeat (A_L1 + LAT - (B_L1 + LAT) - 2) @(negedge clk);
      check("a_l1_before", a_l1, 0);
      @(negedge clk);
      check("a_l1_edge", a_l1, 1);
      check("a_l2_before_edge", a_l2, 0);
      repeat (A_L2 - 1) @(negedge clk);
      check("a_l2_before", a_l2, 0);
      @(negedge clk);
      check("a_l2_edge", a_l2, 1);

      // Random reset pulses
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("locked_a", a_l2, 1);

`ifdef DDR_CLK_FB_CHECK_EN
      // Feedback stops after lock: locks drop after the timeout window
      mode = M_FREE;
      fb_force = 1'b1;
      repeat (FB_T - 2) @(negedge clk);
      check("stuck_hold_l1", a_l1, 1);
      check("stuck_hold_l2", a_l2, 1);
      repeat (8) @(negedge clk);
      check("stuck_drop_l1", a_l1, 0);
      check("stuck_drop_l2", a_l2, 0);
      mode = M_ZERO;
      repeat (200) @(negedge clk);
      // Feedback resumes: bounded wait for relock
      mode = M_FREE;
      fb_force = 1'b0;
      begin
         int t;
         t = 0;
         while (!(a_l2 && b_l2) && t < A_L1 + A_L2 + FB_T + 20) begin
            @(negedge clk);
            t++;
         end
         check("relock_a", a_l2, 1);
         check("relock_b", b_l2, 1);
      end

      // Feedback never toggles from reset: no lock for 1000 cycles
      rst = 1'b1;
      fb_force = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mode = M_ZERO;
      repeat (1000) @(negedge clk);
      check("never_l1", a_l1, 0);
      fb_force = 1'b0;
      mode = M_FREE;
`endif

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
